recibir_datos: RTL
==================

# recibir_datos

Receive-side counterpart of the digit sender: deserialises 8N1 UART frames from the `rx` pin and checks that the payload is the ASCII digit sequence '0'..'9' in ascending order. It reports each accepted digit, a sticky sequence-complete flag and sticky error flags. It sits on the FPGA's UART input pin and pairs with the board that runs the digit transmitter. It contains a self-contained UART receiver plus a sequence checker.

## Interface
- `BAUD`, default 434: clock cycles per bit (434 = 115200 baud at 50 MHz). Legal values are 4 or more.
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high; it clears all state.
- `rx`  in  1  asynchronous serial input, idle high.
- `datos`  out  8  last byte received with a good stop bit; reset 8'h00.
- `valid`  out  1  one-cycle pulse when `datos` is updated; reset 0.
- `digito`  out  4  numeric value of the last in-sequence digit; reset 4'd0.
- `done`  out  1  sticky; set when '9' is accepted in sequence; reset 0.
- `error`  out  1  sticky; set on an out-of-sequence byte; reset 0.
- `frame_err`  out  1  one-cycle pulse when a stop bit samples 0; reset 0.

## Operation
- **Synchroniser:** `rx` passes through 2 flops, both reset to 1. Its output is `rx_s`. All logic uses `rx_s`.
- **Receiver FSM:** states IDLE, START, DATA, STOP. It has a bit-period counter and a 3-bit bit index.
  - IDLE: when `rx_s`==0, load counter = BAUD/2 − 1 (integer division) and go to START.
  - START: at counter==0, sample `rx_s`.
    - 0: load counter = BAUD − 1, clear the bit index, go to DATA.
    - 1: this is a glitch. Return to IDLE with no output.
  - DATA: at counter==0, shift `rx_s` in LSB first and reload BAUD − 1. After bit index 7, go to STOP.
  - STOP: at counter==0, sample `rx_s`.
    - 1: latch the byte into `datos` and pulse `valid`.
    - 0: pulse `frame_err` and discard the byte.
    - Either way, return to IDLE. Back-to-back frames are accepted because IDLE is re-entered mid-stop-bit.
- **Checker:** register `esperado`, reset 8'h30. It acts only on `valid`.
  - `done`==1: the byte is ignored. `error` and `digito` are unchanged.
  - Byte == `esperado`: `digito` = byte − 8'h30 (low 4 bits).
    - If the byte is 8'h39, set `done`.
    - Otherwise `esperado` = `esperado` + 1.
  - Byte != `esperado`: set `error`. `esperado` and `digito` are unchanged, so the expected digit can still be accepted later.
- `frame_err` does not affect the checker.
- `rst` at any point (mid-frame included) returns the FSM to IDLE and sets all outputs and `esperado` to their reset values on the next edge. A frame in progress is lost.

## Timing
- Let T0 be the first edge at which `rx_s`==0 is seen in IDLE. Sample points then fall at:
  - start bit: T0 + BAUD/2;
  - data bit k (k = 0..7): T0 + BAUD/2 + (k+1)·BAUD;
  - stop bit: T0 + BAUD/2 + 9·BAUD.
- `valid` or `frame_err` is high in exactly the cycle after the stop sample.
- `datos` changes in the same cycle `valid` rises.
- `digito`, `done` and `error` update one cycle after `valid`.
- Pin-to-T0 latency is 2 cycles (synchroniser).
- `valid` and `frame_err` are never high in the same cycle.
- The counter width is $clog2(BAUD). It never wraps: it is always reloaded before it underflows.

## Structure
- Package `recibir_datos_pkg` holds:
  - baud constants B115200..B300, with the same values as the transmit side;
  - ASCII_0 = 8'h30 and ASCII_9 = 8'h39;
  - the 2-bit receiver state encodings IDLE/START/DATA/STOP.
- Sub-module `uart_rx` (parameter BAUD): ports clk, rst, rx, data[7:0], valid, frame_err. It contains the synchroniser and the FSM.
- `recibir_datos` instantiates `uart_rx` and implements the checker.

## Test plan
Use BAUD=16 in simulation.
- **Full sequence:** frames '0'..'9' (8'h30..8'h39), 5 idle bit-times apart. Expect 10 `valid` pulses, `digito` 0..9, `done`=1 after the last frame, `error`=0, and `valid` exactly 1 cycle after each stop sample.
- **Out of sequence:** send '0','2','1'. Expect `error`=1 after '2'; `digito`=1 after '1'; `done`=0.
- **Framing error:** send 8'h30 with the stop bit forced to 0. Expect a `frame_err` pulse, no `valid`, and `esperado` still 8'h30 (a following '0' is accepted).
- **Start glitch:** drive `rx` low for 4 cycles, then high. Expect no `valid`, no `frame_err`, and the FSM back in IDLE. The next good frame is received correctly.
- **Reset mid-frame:** assert `rst` for 1 cycle during data bit 3 of '5'. Expect all outputs at reset values. A following frame 8'h30 is accepted with `digito`=0.
- **Back-to-back / after done:** send '0'..'9' with no idle gap, then 'A' (8'h41). Expect all 10 digits accepted, `done`=1, `error` still 0 after 'A', and `datos`=8'h41.

Source files
------------

// File: rtl/recibir_datos_pkg.sv
// Shared constants for the digit-sequence receiver: baud divisors at 50 MHz,
// the ASCII digit bounds and the UART receiver state encoding.
package recibir_datos_pkg;

    localparam int B115200 = 434;
    localparam int B57600  = 868;
    localparam int B38400  = 1302;
    localparam int B19200  = 2604;
    localparam int B9600   = 5208;
    localparam int B4800   = 10417;
    localparam int B2400   = 20833;
    localparam int B1200   = 41667;
    localparam int B600    = 83333;
    localparam int B300    = 166667;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_9 = 8'h39;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/recibir_datos_uart_rx.sv
// 8N1 UART receiver with a two-flop input synchroniser, sampling each bit
// at its centre and flagging frames whose stop bit reads low.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s to fall
// START | half a bit into the start bit, confirming it is still low
// DATA  | shifting in 8 data bits LSB first, one per bit period
// STOP  | checking the stop bit, then publishing the byte or a frame error
module uart_rx
    import recibir_datos_pkg::*;
#(
    parameter int BAUD = B115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int CW = $clog2(BAUD);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD - 1);

    rx_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic valid_q, valid_d;
    logic ferr_q, ferr_d;
    logic rx_m_q, rx_s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m_q  <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            rx_m_q  <= rx;
            rx_s_q  <= rx_m_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    cnt_d   = HALF_M1;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    // A start bit that is high again at mid-bit is line noise.
                    if (!rx_s_q) begin
                        cnt_d   = FULL_M1;
                        idx_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    cnt_d   = FULL_M1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;

endmodule

// File: rtl/recibir_datos.sv
// Digit-sequence receiver: takes bytes from uart_rx and checks they arrive as
// '0'..'9' in order, reporting the accepted digit plus sticky done/error flags.
module recibir_datos
    import recibir_datos_pkg::*;
#(
    parameter int BAUD = B115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] datos,
    output logic       valid,
    output logic [3:0] digito,
    output logic       done,
    output logic       error,
    output logic       frame_err
);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;
    logic [7:0] esperado_q, esperado_d;
    logic [3:0] digito_q, digito_d;
    logic       done_q, done_d;
    logic       error_q, error_d;
    logic [7:0] offset;

    uart_rx #(.BAUD(BAUD)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (rx_data),
        .valid     (rx_valid),
        .frame_err (rx_ferr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            esperado_q <= ASCII_0;
            digito_q   <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            esperado_q <= esperado_d;
            digito_q   <= digito_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign offset = rx_data - ASCII_0;

    always_comb begin
        esperado_d = esperado_q;
        digito_d   = digito_q;
        done_d     = done_q;
        error_d    = error_q;
        // Once the sequence has completed, anything further is ignored.
        if (rx_valid && !done_q) begin
            if (rx_data == esperado_q) begin
                digito_d = offset[3:0];
                if (rx_data == ASCII_9) begin
                    done_d = 1'b1;
                end else begin
                    esperado_d = esperado_q + 8'd1;
                end
            end else begin
                error_d = 1'b1;
            end
        end
    end

    assign datos     = rx_data;
    assign valid     = rx_valid;
    assign frame_err = rx_ferr;
    assign digito    = digito_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
